// File: rtl/alu_cmd_issue.sv
// Issue stage for the gate-level ALU: command FIFO, ALU drive and registered result.
// Define ALU_CMD_ISSUE_FLAGS_EN to add registered zero/carry flag outputs.
module alu_cmd_issue #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    cmd_valid_in,
    output logic                    cmd_ready_out,
    input  logic [2:0]              cmd_sel_in,
    input  logic [DATA_WIDTH-1:0]   cmd_a_in,
    input  logic [DATA_WIDTH-1:0]   cmd_b_in,
    output logic [DATA_WIDTH-1:0]   alu_a_out,
    output logic [DATA_WIDTH-1:0]   alu_b_out,
    output logic [2:0]              alu_sel_out,
    input  logic [2*DATA_WIDTH-1:0] alu_q_in,
    output logic                    res_valid_out,
    input  logic                    res_ready_in,
    output logic [2*DATA_WIDTH-1:0] res_q_out,
    output logic                    res_err_out,
    output logic                    busy_out
`ifdef ALU_CMD_ISSUE_FLAGS_EN
    ,
    output logic                    res_zero_out,
    output logic                    res_cout_out
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int QW    = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_e;

    logic [2:0]            sel_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] a_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] b_mem   [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             res_valid_q, res_valid_d;
    logic [QW-1:0]    result_q, result_d;
    logic             res_err_q, res_err_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    state_e           state_q, state_d;

    logic not_empty;
    logic push;
    logic issue;
    logic head_err;
    logic head_arith;
    logic next_idle;

    always_comb begin
        not_empty     = (count_q != '0);
        cmd_ready_out = (count_q < DEPTH_C) & ~rst_in;
        push          = cmd_valid_in & cmd_ready_out;
        issue         = not_empty & (~res_valid_q | res_ready_in);
        alu_a_out     = '0;
        alu_b_out     = '0;
        alu_sel_out   = '0;
        if (not_empty) begin
            alu_a_out   = a_mem[rd_ptr_q];
            alu_b_out   = b_mem[rd_ptr_q];
            alu_sel_out = sel_mem[rd_ptr_q];
        end
        head_err   = (alu_sel_out >= 3'd5);
        head_arith = (alu_sel_out == 3'd0) | (alu_sel_out == 3'd1);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = issue ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        res_valid_d = res_valid_q;
        result_d    = result_q;
        res_err_d   = res_err_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        if (issue) begin
            res_valid_d = 1'b1;
            result_d    = alu_q_in;
            res_err_d   = head_err;
            zero_d      = (alu_q_in == '0);
            cout_d      = head_arith & alu_q_in[DATA_WIDTH];
        end else if (res_ready_in) begin
            res_valid_d = 1'b0;
        end
    end

    // Idle is judged on next-cycle occupancy so busy_out never lags the datapath.
    always_comb begin
        next_idle = (count_d == '0) & ~res_valid_d;
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = RUN;
            end
            RUN: begin
                if (next_idle)
                    state_d = IDLE;
                else if (res_valid_q & ~res_ready_in & not_empty)
                    state_d = STALL;
            end
            STALL: begin
                if (res_ready_in) state_d = next_idle ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            sel_mem[wr_ptr_q] <= cmd_sel_in;
            a_mem[wr_ptr_q]   <= cmd_a_in;
            b_mem[wr_ptr_q]   <= cmd_b_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            res_err_q   <= 1'b0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            state_q     <= IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            res_err_q   <= res_err_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            state_q     <= state_d;
        end
    end

    assign res_valid_out = res_valid_q;
    assign res_q_out     = result_q;
    assign res_err_out   = res_err_q;
    assign busy_out      = (state_q != IDLE);

`ifdef ALU_CMD_ISSUE_FLAGS_EN
    assign res_zero_out = zero_q;
    assign res_cout_out = cout_q;
`else
    logic unused_flags;
    assign unused_flags = zero_q ^ cout_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: queue-level reference model plus directed vectors.
// Also exercises the ALU_CMD_ISSUE_FLAGS_EN flag ports when that macro is defined.
module tb_alu_cmd_issue;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         cmd_valid_in = 1'b0;
    logic         cmd_ready_out;
    logic [2:0]   cmd_sel_in = '0;
    logic [W-1:0] cmd_a_in = '0;
    logic [W-1:0] cmd_b_in = '0;
    logic [W-1:0] alu_a_out;
    logic [W-1:0] alu_b_out;
    logic [2:0]   alu_sel_out;
    logic [2*W-1:0] alu_q_in;
    logic         res_valid_out;
    logic         res_ready_in = 1'b0;
    logic [2*W-1:0] res_q_out;
    logic         res_err_out;
    logic         busy_out;
`ifdef ALU_CMD_ISSUE_FLAGS_EN
    logic         res_zero_out;
    logic         res_cout_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    // Stand-in for the gate-level ALU: opcode semantics at 2*W bits.
    function automatic logic [2*W-1:0] alu_ref(input logic [2:0] s,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] r;
        case (s)
            3'd0:    r = 8'(a) + 8'(b);
            3'd1:    r = 8'(a) - 8'(b);
            3'd2:    r = 8'(a) * 8'(b);
            3'd3:    r = {4'h0, ~(a & b)};
            3'd4:    r = {4'h0, ~(a | b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_q_in = alu_ref(alu_sel_out, alu_a_out, alu_b_out);

    alu_cmd_issue #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in),
        .cmd_ready_out(cmd_ready_out),
        .cmd_sel_in(cmd_sel_in),
        .cmd_a_in(cmd_a_in),
        .cmd_b_in(cmd_b_in),
        .alu_a_out(alu_a_out),
        .alu_b_out(alu_b_out),
        .alu_sel_out(alu_sel_out),
        .alu_q_in(alu_q_in),
        .res_valid_out(res_valid_out),
        .res_ready_in(res_ready_in),
        .res_q_out(res_q_out),
        .res_err_out(res_err_out),
        .busy_out(busy_out)
`ifdef ALU_CMD_ISSUE_FLAGS_EN
        ,
        .res_zero_out(res_zero_out),
        .res_cout_out(res_cout_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands and one output slot.
    cmd_t           mq[$];
    cmd_t           m_c;
    bit             m_psh;
    logic           m_valid = 1'b0;
    logic           m_err = 1'b0;
    logic [2*W-1:0] m_q = '0;
    logic           m_zero = 1'b0;
    logic           m_cout = 1'b0;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mq.delete();
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_q     = '0;
            m_zero  = 1'b0;
            m_cout  = 1'b0;
        end else begin
            m_psh = cmd_valid_in && (mq.size() < D);
            if (mq.size() != 0 && (!m_valid || res_ready_in)) begin
                m_c     = mq.pop_front();
                m_q     = alu_ref(m_c.s, m_c.a, m_c.b);
                m_err   = (m_c.s >= 3'd5);
                m_valid = 1'b1;
                m_zero  = (m_q == '0);
                m_cout  = (m_c.s <= 3'd1) ? m_q[W] : 1'b0;
            end else if (res_ready_in) begin
                m_valid = 1'b0;
            end
            if (m_psh) mq.push_back({cmd_sel_in, cmd_a_in, cmd_b_in});
        end
    end

    always @(negedge clk_in) begin
        chk("ready", cmd_ready_out, (mq.size() < D) && !rst_in);
        chk("valid", res_valid_out, m_valid);
        chk("q", res_q_out, m_q);
        chk("err", res_err_out, m_err);
        chk("busy", busy_out, (mq.size() != 0) || m_valid);
        if (mq.size() != 0) begin
            chk("alu_a", alu_a_out, mq[0].a);
            chk("alu_b", alu_b_out, mq[0].b);
            chk("alu_sel", alu_sel_out, mq[0].s);
        end else begin
            chk("alu_a", alu_a_out, 0);
            chk("alu_b", alu_b_out, 0);
            chk("alu_sel", alu_sel_out, 0);
        end
`ifdef ALU_CMD_ISSUE_FLAGS_EN
        chk("zero", res_zero_out, m_zero);
        chk("cout", res_cout_out, m_cout);
`endif
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        cmd_valid_in = 1'b1;
        cmd_sel_in   = s;
        cmd_a_in     = a;
        cmd_b_in     = b;
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_valid", res_valid_out, 0);
        chk("rst_q", res_q_out, 0);
        chk("rst_err", res_err_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", cmd_ready_out, 0);
        rst_in = 1'b0;

        // Single add, 9+8 = 0x11, result slot then held
        res_ready_in = 1'b0;
        drive(3'd0, 4'd9, 4'd8);
        step();
        cmd_valid_in = 1'b0;
        step();
        chk("single_valid", res_valid_out, 1);
        chk("single_q", res_q_out, 8'h11);
        chk("single_err", res_err_out, 0);

        // Backpressure with the slot occupied: four fill the FIFO
        drive(3'd0, 4'd1, 4'd2);
        step();
        drive(3'd1, 4'd7, 4'd3);
        step();
        drive(3'd2, 4'd4, 4'd4);
        step();
        drive(3'd3, 4'hA, 4'h5);
        step();
        drive(3'd4, 4'h0, 4'h1);
        chk("bp_full_ready", cmd_ready_out, 0);
        chk("bp_busy", busy_out, 1);
        step();
        chk("bp_hold_q", res_q_out, 8'h11);
        res_ready_in = 1'b1;
        step();
        chk("bp_q0", res_q_out, 8'h03);
        step();
        chk("bp_q1", res_q_out, 8'h04);
        cmd_valid_in = 1'b0;
        step();
        chk("bp_q2", res_q_out, 8'h10);
        step();
        chk("bp_q3", res_q_out, 8'h0F);
        step();
        chk("bp_q4", res_q_out, 8'h0E);
        step();
        chk("bp_drained_valid", res_valid_out, 0);
        chk("bp_drained_busy", busy_out, 0);

        // Streaming, one result per cycle
        drive(3'd2, 4'd3, 4'd5);
        step();
        drive(3'd1, 4'd2, 4'd5);
        step();
        chk("stream_mul", res_q_out, 8'h0F);
        drive(3'd3, 4'hF, 4'hF);
        step();
        chk("stream_sub", res_q_out, 8'hFD);
        cmd_valid_in = 1'b0;
        step();
        chk("stream_nand", res_q_out, 8'h00);
        chk("stream_valid", res_valid_out, 1);
        step();
        step();

        // Illegal opcode, then a legal one clears the error
        drive(3'd6, 4'd1, 4'd1);
        step();
        cmd_valid_in = 1'b0;
        step();
        chk("illegal_q", res_q_out, 8'h00);
        chk("illegal_err", res_err_out, 1);
        drive(3'd0, 4'd1, 4'd1);
        step();
        cmd_valid_in = 1'b0;
        step();
        chk("legal_err", res_err_out, 0);
        chk("legal_q", res_q_out, 8'h02);
        step();

`ifdef ALU_CMD_ISSUE_FLAGS_EN
        drive(3'd0, 4'd8, 4'd8);
        step();
        cmd_valid_in = 1'b0;
        step();
        chk("flag_add_q", res_q_out, 8'h10);
        chk("flag_add_cout", res_cout_out, 1);
        chk("flag_add_zero", res_zero_out, 0);
        drive(3'd4, 4'hF, 4'hF);
        step();
        cmd_valid_in = 1'b0;
        step();
        chk("flag_nor_zero", res_zero_out, 1);
        chk("flag_nor_cout", res_cout_out, 0);
        step();
`endif

        // Asynchronous reset mid-stream with commands queued
        res_ready_in = 1'b0;
        drive(3'd0, 4'd2, 4'd3);
        step();
        drive(3'd2, 4'd2, 4'd3);
        step();
        drive(3'd1, 4'd9, 4'd3);
        step();
        drive(3'd4, 4'd1, 4'd3);
        step();
        cmd_valid_in = 1'b0;
        chk("pre_rst_busy", busy_out, 1);
        #1;
        rst_in = 1'b1;
        #1;
        chk("arst_valid", res_valid_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_ready", cmd_ready_out, 0);
        chk("arst_q", res_q_out, 0);
        step();
        rst_in = 1'b0;
        res_ready_in = 1'b1;
        repeat (4) step();
        chk("post_rst_valid", res_valid_out, 0);
        chk("post_rst_busy", busy_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
